// File: rtl/j1_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : j1_pipe_ctrl
// Description : Pipeline sequencing controller for the J1 stack CPU. It sits
//               beside the EX->WB pipeline register. It produces the per-stage
//               hold and flush controls that handle three cases:
//                 - fixed-latency memory-read wait states,
//                 - a multi-cycle squash after a taken jump or call,
//                 - a debug halt.
//               All outputs are decoded from registered state only (Moore).
// Parameters  : MEM_WAIT  - extra stall cycles per memory read (0 = none)
//               FLUSH_CYC - cycles flush_o is held after a jump (1..2^CNT_W)
//               CNT_W     - width of the wait/flush down-counter
// Ports       : clk, rst (sync, active-high)
//               jump_flag_i, call_en_i, mem_ren_i, mem_wen_i, hold_flag_i
//               pc_hold_o, if_hold_o, id_hold_o, flush_o
//               state_o (0 RUN, 1 MWAIT, 2 FLUSH, 3 HALT)
//               stall_cnt_o (statistics counter)
// Options     : J1_PIPE_STAT_EN - when defined, stall_cnt_o counts MWAIT/HALT
//               cycles and saturates at 16'hFFFF. When undefined, it is tied
//               to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module j1_pipe_ctrl #(
    parameter int MEM_WAIT  = 2,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic        call_en_i,
    input  logic        mem_ren_i,
    input  logic        mem_wen_i,
    input  logic        hold_flag_i,
    output logic        pc_hold_o,
    output logic        if_hold_o,
    output logic        id_hold_o,
    output logic        flush_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Counter load values are truncated to CNT_W bits. The counter counts down
    // to zero, so the state lasts for (load + 1) cycles.
    localparam logic [CNT_W-1:0] C_FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] C_MEM_LOAD   = CNT_W'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);
    localparam bit               C_MEM_STALL  = (MEM_WAIT > 0);

    if ((FLUSH_CYC > (1 << CNT_W)) || (FLUSH_CYC < 1)) begin : g_cfg_err
        $error("j1_pipe_ctrl: FLUSH_CYC=%0d is out of range for CNT_W=%0d", FLUSH_CYC, CNT_W);
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pend_jmp, pend_jmp_nxt;
    logic             jmp;

    // A call sequences exactly like a jump.
    assign jmp = jump_flag_i | call_en_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            cnt      <= '0;
            pend_jmp <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pend_jmp <= pend_jmp_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pend_jmp_nxt = pend_jmp;
        pc_hold_o    = 1'b0;
        if_hold_o    = 1'b0;
        id_hold_o    = 1'b0;
        flush_o      = 1'b0;

        case (state)
            ST_RUN: begin
                // A write, with or without a read, never stalls by itself.
                // A simultaneous read and write stalls because of the read.
                if (jmp) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = C_FLUSH_LOAD;
                end else if (mem_ren_i && C_MEM_STALL) begin
                    state_nxt = ST_MWAIT;
                    cnt_nxt   = C_MEM_LOAD;
                end else if (hold_flag_i) begin
                    state_nxt = ST_HALT;
                end
            end

            ST_MWAIT: begin
                pc_hold_o = 1'b1;
                if_hold_o = 1'b1;
                id_hold_o = 1'b1;
                // A jump that completes during the wait is remembered. A hold
                // request is left for RUN to pick up.
                if (cnt == '0) begin
                    if (pend_jmp || jmp) begin
                        state_nxt    = ST_FLUSH;
                        cnt_nxt      = C_FLUSH_LOAD;
                        pend_jmp_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    if (jmp) begin
                        pend_jmp_nxt = 1'b1;
                    end
                end
            end

            ST_FLUSH: begin
                // Holds stay low so the PC can load the jump target. Requests
                // that arrive now come from squashed instructions and are dropped.
                flush_o = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            ST_HALT: begin
                pc_hold_o = 1'b1;
                if_hold_o = 1'b1;
                id_hold_o = 1'b1;
                if (hold_flag_i) begin
                    if (jmp) begin
                        pend_jmp_nxt = 1'b1;
                    end
                end else if (pend_jmp || jmp) begin
                    state_nxt    = ST_FLUSH;
                    cnt_nxt      = C_FLUSH_LOAD;
                    pend_jmp_nxt = 1'b0;
                end else begin
                    state_nxt = ST_RUN;
                end
            end

            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign state_o = state;

`ifdef J1_PIPE_STAT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if (((state == ST_MWAIT) || (state == ST_HALT)) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_j1_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_j1_pipe_ctrl
// Description : Directed self-checking bench for j1_pipe_ctrl with default
//               parameters (MEM_WAIT=2, FLUSH_CYC=2). Expected values are
//               hand-computed per cycle. After each edge the bench samples the
//               outputs at #1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_j1_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i, call_en_i, mem_ren_i, mem_wen_i, hold_flag_i;
    logic        pc_hold_o, if_hold_o, id_hold_o, flush_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    j1_pipe_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .jump_flag_i (jump_flag_i),
        .call_en_i   (call_en_i),
        .mem_ren_i   (mem_ren_i),
        .mem_wen_i   (mem_wen_i),
        .hold_flag_i (hold_flag_i),
        .pc_hold_o   (pc_hold_o),
        .if_hold_o   (if_hold_o),
        .id_hold_o   (id_hold_o),
        .flush_o     (flush_o),
        .state_o     (state_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks state plus the packed {pc,if,id,flush} controls.
    task automatic chk_st(input string tag, input logic [1:0] st, input logic [3:0] ctl);
        chk({tag, ".state"}, {14'd0, state_o}, {14'd0, st});
        chk({tag, ".ctl"}, {12'd0, pc_hold_o, if_hold_o, id_hold_o, flush_o}, {12'd0, ctl});
    endtask

    localparam logic [3:0] C_IDLE  = 4'b0000;
    localparam logic [3:0] C_HOLD  = 4'b1110;
    localparam logic [3:0] C_FLUSH = 4'b0001;

    logic [15:0] exp_stall;

    initial begin
        rst = 1'b1; jump_flag_i = 0; call_en_i = 0; mem_ren_i = 0; mem_wen_i = 0; hold_flag_i = 0;
        tick(); tick();
        rst = 1'b0;

        // 1. Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_st("idle", 2'd0, C_IDLE);
        end
        chk("idle.stall", stall_cnt_o, 16'h0000);

        // 2. Memory read: two wait cycles, then RUN
        mem_ren_i = 1; tick(); mem_ren_i = 0;
        chk_st("mw1", 2'd1, C_HOLD);
        tick(); chk_st("mw2", 2'd1, C_HOLD);
        tick(); chk_st("mw_end", 2'd0, C_IDLE);
`ifdef J1_PIPE_STAT_EN
        exp_stall = 16'd2;
`else
        exp_stall = 16'd0;
`endif
        chk("mw.stall", stall_cnt_o, exp_stall);

        // A write alone never stalls
        mem_wen_i = 1; tick(); mem_wen_i = 0;
        chk_st("wen_only", 2'd0, C_IDLE);

        // A read and a write together stall like a read
        mem_ren_i = 1; mem_wen_i = 1; tick(); mem_ren_i = 0; mem_wen_i = 0;
        chk_st("renwen1", 2'd1, C_HOLD);
        tick(); tick(); chk_st("renwen_end", 2'd0, C_IDLE);

        // 3. Jump: two flush cycles. A read during the flush is ignored.
        jump_flag_i = 1; tick(); jump_flag_i = 0;
        chk_st("fl1", 2'd2, C_FLUSH);
        mem_ren_i = 1; tick(); mem_ren_i = 0;
        chk_st("fl2", 2'd2, C_FLUSH);
        tick(); chk_st("fl_end", 2'd0, C_IDLE);
        tick(); chk_st("fl_noren", 2'd0, C_IDLE);

        // A call sequences like a jump
        call_en_i = 1; tick(); call_en_i = 0;
        chk_st("call1", 2'd2, C_FLUSH);
        tick(); tick(); chk_st("call_end", 2'd0, C_IDLE);

        // 4. Read then jump during the wait: MWAIT x2, FLUSH x2, RUN
        mem_ren_i = 1; tick(); mem_ren_i = 0;
        chk_st("rj_mw1", 2'd1, C_HOLD);
        jump_flag_i = 1; tick(); jump_flag_i = 0;
        chk_st("rj_mw2", 2'd1, C_HOLD);
        tick(); chk_st("rj_fl1", 2'd2, C_FLUSH);
        tick(); chk_st("rj_fl2", 2'd2, C_FLUSH);
        tick(); chk_st("rj_run", 2'd0, C_IDLE);

        // 5. Hold for 6 sampled cycles with a jump in the third -> HALT x6, FLUSH x2
        hold_flag_i = 1;
        tick(); chk_st("h1", 2'd3, C_HOLD);
        tick(); chk_st("h2", 2'd3, C_HOLD);
        jump_flag_i = 1; tick(); jump_flag_i = 0;
        chk_st("h3", 2'd3, C_HOLD);
        tick(); tick();
        tick(); chk_st("h6", 2'd3, C_HOLD);
        hold_flag_i = 0;
        tick(); chk_st("h_fl1", 2'd2, C_FLUSH);
        tick(); chk_st("h_fl2", 2'd2, C_FLUSH);
        tick(); chk_st("h_run", 2'd0, C_IDLE);
`ifdef J1_PIPE_STAT_EN
        exp_stall = 16'd2 + 16'd2 + 16'd2 + 16'd6;
`else
        exp_stall = 16'd0;
`endif
        chk("h.stall", stall_cnt_o, exp_stall);

        // A hold raised during a wait is taken only after the wait ends
        mem_ren_i = 1; tick(); mem_ren_i = 0;
        hold_flag_i = 1;
        tick(); chk_st("mwh2", 2'd1, C_HOLD);
        tick(); chk_st("mwh_run", 2'd0, C_IDLE);
        tick(); chk_st("mwh_halt", 2'd3, C_HOLD);
        hold_flag_i = 0;
        tick(); chk_st("mwh_rel", 2'd0, C_IDLE);

        // 6. Reset in the first MWAIT cycle also drops a jump seen in that cycle
        mem_ren_i = 1; tick(); mem_ren_i = 0;
        chk_st("r_mw1", 2'd1, C_HOLD);
        rst = 1; jump_flag_i = 1; tick(); rst = 0; jump_flag_i = 0;
        chk_st("r_run", 2'd0, C_IDLE);
        chk("r.stall", stall_cnt_o, 16'h0000);
        tick(); chk_st("r_nopend", 2'd0, C_IDLE);
        mem_ren_i = 1; tick(); mem_ren_i = 0;
        chk_st("r2_mw1", 2'd1, C_HOLD);
        tick(); chk_st("r2_mw2", 2'd1, C_HOLD);
        tick(); chk_st("r2_run", 2'd0, C_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
